// File: rtl/conv_feeder_pkg.sv
// Shared types and constants for the conv window feeder.
// Geometry, npu bus encodings and small index helpers.
package conv_feeder_pkg;

    localparam int K_H   = 3;
    localparam int K_W   = 3;
    localparam int IN1_H = 16;
    localparam int IN1_W = 15;
    localparam int GAP   = 3;

    localparam int SW = $clog2(K_H);
    localparam int CW = $clog2(IN1_W);
    localparam int RW = $clog2(IN1_H);
    localparam int GW = $clog2(GAP + 1);

    localparam logic [2:0] SEL_IMG = 3'b001;
    localparam logic [2:0] SEL_CMD = 3'b100;

    localparam logic [31:0] CMD_TRIGGER = 32'h0000_0001;
    localparam logic [31:0] CMD_NEXT    = 32'h0000_0002;
    localparam logic [31:0] CMD_IMG_CLR = 32'h0000_0008;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FILL,
        S_CLR,
        S_PRIME,
        S_COL,
        S_TRIG,
        S_GAP,
        S_REFILL,
        S_FIN,
        S_DONE
    } state_t;

    function automatic logic [15:0] bus_addr(input logic [2:0] sel);
        return {1'b0, sel, 12'h000};
    endfunction

    // Circular slot index: (top + k) mod K_H
    function automatic logic [SW-1:0] slot_add(
        input logic [SW-1:0] top,
        input int unsigned   k
    );
        int unsigned s;
        s = int'(top) + k;
        while (s >= K_H) s = s - K_H;
        return s[SW-1:0];
    endfunction

endpackage

// File: rtl/conv_win_feeder_line_buf.sv
// Circular K_H x IN1_W byte line buffer for the conv window feeder.
// One byte write port, one K_H-byte column read port ordered from slot top.
module line_buf_3row
    import conv_feeder_pkg::*;
(
    input  logic             clk,
    input  logic             we_i,
    input  logic [SW-1:0]    wr_slot_i,
    input  logic [CW-1:0]    wr_col_i,
    input  logic [7:0]       wr_data_i,
    input  logic [SW-1:0]    rd_top_i,
    input  logic [CW-1:0]    rd_col_i,
    output logic [8*K_H-1:0] rd_data_o
);

    logic [7:0] mem_q [K_H][IN1_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_slot_i][wr_col_i] <= wr_data_i;
        end
    end

    // Byte k of the column comes from the k-th oldest stored row
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < K_H; k++) begin
            rd_data_o[8*k +: 8] = mem_q[slot_add(rd_top_i, k)][rd_col_i];
        end
    end

endmodule

// File: rtl/conv_win_feeder.sv
// Raster-to-npu conv window feeder with a shared npu write port.
// Optional CONV_FEEDER_STATS_EN adds win_cnt / stall_cnt outputs.
module conv_win_feeder
    import conv_feeder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        npu_ena,
    output logic        npu_wea,
    output logic [15:0] npu_addra,
    output logic [31:0] npu_dina,
    output logic        busy,
    output logic        done
`ifdef CONV_FEEDER_STATS_EN
    ,
    output logic [15:0] win_cnt,
    output logic [15:0] stall_cnt
`endif
);

    state_t        state_q;
    logic [SW-1:0] top_q;
    logic [SW-1:0] fill_row_q;
    logic [CW-1:0] col_q;
    logic [CW-1:0] c_q;
    logic [RW-1:0] orow_q;
    logic [GW-1:0] gap_q;
    logic          s_ready_q;
    logic          bus_req_q;
    logic [15:0]   addr_q;
    logic [31:0]   dina_q;
    logic          busy_q;
    logic          done_q;

    logic             acc;
    logic             fire;
    logic             last_px;
    logic [SW-1:0]    wr_slot_d;
    logic [CW-1:0]    rd_col_d;
    logic [8*K_H-1:0] lb_col;
    logic [31:0]      col_word;

    assign acc     = s_valid & s_ready_q;
    assign fire    = bus_req_q & bus_gnt;
    assign last_px = (col_q == CW'(IN1_W - 1));

    assign wr_slot_d = (state_q == S_FILL) ? fill_row_q : top_q;

    // Column of the word loaded on this edge: 0 after a clear, else c+1
    always_comb begin
        rd_col_d = '0;
        if (state_q != S_CLR && c_q != CW'(IN1_W - 1)) begin
            rd_col_d = c_q + 1'b1;
        end
    end

    assign col_word = {{(32 - 8*K_H){1'b0}}, lb_col};

    line_buf_3row u_lbuf (
        .clk       (clk),
        .we_i      (acc),
        .wr_slot_i (wr_slot_d),
        .wr_col_i  (col_q),
        .wr_data_i (s_data),
        .rd_top_i  (top_q),
        .rd_col_i  (rd_col_d),
        .rd_data_o (lb_col)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            top_q      <= '0;
            fill_row_q <= '0;
            col_q      <= '0;
            c_q        <= '0;
            orow_q     <= '0;
            gap_q      <= '0;
            s_ready_q  <= 1'b0;
            bus_req_q  <= 1'b0;
            addr_q     <= '0;
            dina_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        top_q      <= '0;
                        fill_row_q <= '0;
                        col_q      <= '0;
                        c_q        <= '0;
                        orow_q     <= '0;
                        s_ready_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (acc) begin
                        if (last_px) begin
                            col_q <= '0;
                            if (fill_row_q == SW'(K_H - 1)) begin
                                s_ready_q <= 1'b0;
                                bus_req_q <= 1'b1;
                                addr_q    <= bus_addr(SEL_CMD);
                                dina_q    <= CMD_IMG_CLR;
                                state_q   <= S_CLR;
                            end else begin
                                fill_row_q <= fill_row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    if (fire) begin
                        c_q     <= '0;
                        addr_q  <= bus_addr(SEL_IMG);
                        dina_q  <= col_word;
                        state_q <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (fire) begin
                        c_q    <= c_q + 1'b1;
                        dina_q <= col_word;
                        if (c_q == CW'(K_W - 2)) begin
                            state_q <= S_COL;
                        end
                    end
                end
                S_COL: begin
                    if (fire) begin
                        addr_q  <= bus_addr(SEL_CMD);
                        dina_q  <= CMD_TRIGGER;
                        state_q <= S_TRIG;
                    end
                end
                S_TRIG: begin
                    if (fire) begin
                        bus_req_q <= 1'b0;
                        gap_q     <= GW'(GAP);
                        state_q   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_q > GW'(1)) begin
                        gap_q <= gap_q - 1'b1;
                    end else begin
                        gap_q <= '0;
                        if (c_q < CW'(IN1_W - 1)) begin
                            c_q       <= c_q + 1'b1;
                            bus_req_q <= 1'b1;
                            addr_q    <= bus_addr(SEL_IMG);
                            dina_q    <= col_word;
                            state_q   <= S_COL;
                        end else if (orow_q < RW'(IN1_H - K_H)) begin
                            s_ready_q <= 1'b1;
                            col_q     <= '0;
                            state_q   <= S_REFILL;
                        end else begin
                            bus_req_q <= 1'b1;
                            addr_q    <= bus_addr(SEL_CMD);
                            dina_q    <= CMD_NEXT;
                            state_q   <= S_FIN;
                        end
                    end
                end
                S_REFILL: begin
                    if (acc) begin
                        if (last_px) begin
                            col_q     <= '0;
                            s_ready_q <= 1'b0;
                            top_q     <= slot_add(top_q, 1);
                            orow_q    <= orow_q + 1'b1;
                            bus_req_q <= 1'b1;
                            addr_q    <= bus_addr(SEL_CMD);
                            dina_q    <= CMD_IMG_CLR;
                            state_q   <= S_CLR;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_FIN: begin
                    if (fire) begin
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign bus_req   = bus_req_q;
    assign npu_ena   = fire;
    assign npu_wea   = fire;
    assign npu_addra = addr_q;
    assign npu_dina  = dina_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef CONV_FEEDER_STATS_EN
    logic [15:0] win_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            win_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_q == S_TRIG && fire) begin
                win_cnt_q <= win_cnt_q + 1'b1;
            end
            if (bus_req_q && !bus_gnt) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    assign win_cnt   = win_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_win_feeder.sv
// Directed bench for conv_win_feeder: word stream, counts, stalls, abort.
// Stats checks compile in when CONV_FEEDER_STATS_EN is defined.
module tb_conv_win_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        bus_req;
    logic        bus_gnt;
    logic        npu_ena;
    logic        npu_wea;
    logic [15:0] npu_addra;
    logic [31:0] npu_dina;
    logic        busy;
    logic        done;
`ifdef CONV_FEEDER_STATS_EN
    logic [15:0] win_cnt;
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    conv_win_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .bus_req   (bus_req),
        .bus_gnt   (bus_gnt),
        .npu_ena   (npu_ena),
        .npu_wea   (npu_wea),
        .npu_addra (npu_addra),
        .npu_dina  (npu_dina),
        .busy      (busy),
        .done      (done)
`ifdef CONV_FEEDER_STATS_EN
        ,
        .win_cnt   (win_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Pixel source: p[r][c] = (r*15+c) mod 256 = stream index mod 256
    int pix_idx = 0;
    always begin
        logic a, c;
        @(negedge clk);
        a = s_valid && s_ready;
        c = start && !busy;
        @(posedge clk);
        #1;
        if (c) pix_idx = 0;
        else if (a) pix_idx = pix_idx + 1;
        s_data = 8'(pix_idx);
    end

    logic toggle = 1'b0;
    always begin
        @(posedge clk);
        #1;
        bus_gnt = toggle ? ~bus_gnt : 1'b1;
    end

    // Bus monitor
    logic [15:0] log_a[$];
    logic [31:0] log_d[$];
    int n_words, n_trig, n_clr, n_col, n_nxt, n_done;
    int gap_err, done_err, stab_err, wea_err, stall_obs, idle;
    logic after_trig, prev_nxt, prev_stall, got_rf;
    logic [15:0] pa;
    logic [31:0] pd, refill_col;

    always @(negedge clk) begin
        if (npu_ena) begin
            log_a.push_back(npu_addra);
            log_d.push_back(npu_dina);
            n_words++;
            if (npu_addra == 16'h4000 && npu_dina == 32'h1) n_trig++;
            else if (npu_addra == 16'h4000 && npu_dina == 32'h8) n_clr++;
            else if (npu_addra == 16'h4000 && npu_dina == 32'h2) n_nxt++;
            else if (npu_addra == 16'h1000) begin
                n_col++;
                if (n_clr == 2 && !got_rf) begin
                    refill_col = npu_dina;
                    got_rf = 1'b1;
                end
            end
            if (after_trig && npu_addra == 16'h1000 && idle != 3) gap_err++;
            after_trig = (npu_addra == 16'h4000 && npu_dina == 32'h1);
            idle = 0;
        end else begin
            idle++;
        end
        if (npu_wea !== npu_ena) wea_err++;
        if (done) begin
            n_done++;
            if (!prev_nxt) done_err++;
        end
        prev_nxt = npu_ena && npu_addra == 16'h4000 && npu_dina == 32'h2;
        if (prev_stall && (npu_addra !== pa || npu_dina !== pd || !bus_req)) stab_err++;
        prev_stall = bus_req && !bus_gnt;
        pa = npu_addra;
        pd = npu_dina;
        if (bus_req && !bus_gnt) stall_obs++;
    end

    task automatic clr_mon();
        @(posedge clk);
        #2;
        log_a.delete();
        log_d.delete();
        n_words = 0; n_trig = 0; n_clr = 0; n_col = 0; n_nxt = 0; n_done = 0;
        gap_err = 0; done_err = 0; stab_err = 0; wea_err = 0; stall_obs = 0;
        idle = 0; after_trig = 0; prev_nxt = 0; prev_stall = 0; got_rf = 0;
        refill_col = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (n_done == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(n_done != 0), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_layer(input string tag);
        chk({tag, "_w0_a"}, 32'(log_a[0]), 32'h4000);
        chk({tag, "_w0_d"}, log_d[0], 32'h8);
        chk({tag, "_w1_a"}, 32'(log_a[1]), 32'h1000);
        chk({tag, "_w1_d"}, log_d[1], 32'h001E0F00);
        chk({tag, "_w2_d"}, log_d[2], 32'h001F1001);
        chk({tag, "_w3_d"}, log_d[3], 32'h00201102);
        chk({tag, "_w4_a"}, 32'(log_a[4]), 32'h4000);
        chk({tag, "_w4_d"}, log_d[4], 32'h1);
        chk({tag, "_trig"}, n_trig, 182);
        chk({tag, "_clr"}, n_clr, 14);
        chk({tag, "_col"}, n_col, 210);
        chk({tag, "_next"}, n_nxt, 1);
        chk({tag, "_words"}, n_words, 407);
        chk({tag, "_done_n"}, n_done, 1);
        chk({tag, "_done_after_next"}, done_err, 0);
        chk({tag, "_refill_col"}, refill_col, 32'h002D1E0F);
        chk({tag, "_wea_eq_ena"}, wea_err, 0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n, w;
        rst = 1'b1;
        start = 1'b0;
        s_valid = 1'b1;
        s_data = '0;
        bus_gnt = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_ena", 32'(npu_ena), 0);
        chk("rst_wea", 32'(npu_wea), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addra", 32'(npu_addra), 0);
        chk("rst_dina", npu_dina, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Layer with gnt tied high, plus an ignored second start
        clr_mon();
        pulse_start();
        @(negedge clk);
        chk("a_busy", 32'(busy), 1);
        chk("a_s_ready", 32'(s_ready), 1);
        repeat (8) @(posedge clk);
        pulse_start();
        wait_done("a_done_seen", 4000);
        chk_layer("a");
        chk("a_gap", gap_err, 0);
`ifdef CONV_FEEDER_STATS_EN
        chk("a_win_cnt", 32'(win_cnt), 182);
        chk("a_stall_cnt", 32'(stall_cnt), 0);
`endif

        // Layer with gnt toggling every cycle
        @(posedge clk);
        #1 toggle = 1'b1;
        clr_mon();
        pulse_start();
        wait_done("b_done_seen", 8000);
        chk_layer("b");
        chk("b_stable", stab_err, 0);
        chk("b_stalled", 32'(stall_obs > 0), 1);
`ifdef CONV_FEEDER_STATS_EN
        chk("b_win_cnt", 32'(win_cnt), 182);
        chk("b_stall_cnt", 32'(stall_cnt), 32'(stall_obs));
`endif
        @(posedge clk);
        #1 toggle = 1'b0;

        // Abort in the gap after the first trigger
        clr_mon();
        pulse_start();
        n = 0;
        while (n_trig == 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("c_first_trig", n_trig, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("c_bus_req", 32'(bus_req), 0);
        chk("c_ena", 32'(npu_ena), 0);
        chk("c_s_ready", 32'(s_ready), 0);
        chk("c_busy", 32'(busy), 0);
        chk("c_done", 32'(done), 0);
        chk("c_addra", 32'(npu_addra), 0);
        chk("c_dina", npu_dina, 0);
        w = n_words;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("c_no_trailing", n_words, w);
        chk("c_idle_busy", 32'(busy), 0);

        // Clean layer after the abort
        clr_mon();
        pulse_start();
        wait_done("d_done_seen", 4000);
        chk_layer("d");
        chk("d_gap", gap_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
